// File: rtl/debounce_event_pkg.sv
// Shared types and helpers for the debounce/event controller.
// Event payloads are sized for the largest supported channel count (32).
package debounce_event_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_IDX_W   = 5;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] index;
        logic                 rise;
    } evt_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, tick-based stability counter,
// debounced level, and a one-cycle edge pulse with the new level as polarity.
module debounce_channel
    import debounce_event_pkg::*;
#(
    parameter int STABLE_TICKS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic state,
    output logic edge_pulse,
    output logic edge_rise
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   state_q;
    logic                   sync;
    logic                   mismatch;
    logic                   flip;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = (sync != state_q);
    // The flip happens on the STABLE_TICKS-th consecutive mismatching tick.
    assign flip     = tick && mismatch && (cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt     <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (!mismatch) begin
                cnt <= '0;
            end else if (flip) begin
                state_q <= sync;
                cnt     <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign state      = state_q;
    assign edge_pulse = flip;
    assign edge_rise  = sync;

endmodule

// File: rtl/debounce_event_ctrl.sv
// Multi-channel debounce controller: shared sample prescaler, per-channel
// pending events with sticky overrun, round-robin serialisation onto one port.
module debounce_event_ctrl
    import debounce_event_pkg::*;
#(
    parameter int NUM_INPUTS   = 8,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 16,
    localparam int IW          = clog2_min1(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  overrun_clr,
    output logic [NUM_INPUTS-1:0] state,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IW-1:0]         evt_index,
    output logic                  evt_rise,
    output logic [NUM_INPUTS-1:0] overrun
);

    localparam int PW = clog2_min1(PRESCALE);

    logic [PW-1:0]         pcnt;
    logic                  tick;
    logic [NUM_INPUTS-1:0] edge_pulse;
    logic [NUM_INPUTS-1:0] edge_rise;
    logic [NUM_INPUTS-1:0] pend, pend_d;
    logic [NUM_INPUTS-1:0] pol, pol_d;
    logic [NUM_INPUTS-1:0] ovr_set;
    logic [NUM_INPUTS-1:0] take;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         grant_idx;
    logic [IW-1:0]         cand;
    logic                  grant_found;
    logic                  load;
    evt_t                  evt_q;
    logic                  evt_unused;

    assign tick = (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .raw       (in[g]),
            .tick      (tick),
            .state     (state[g]),
            .edge_pulse(edge_pulse[g]),
            .edge_rise (edge_rise[g])
        );
    end

    // Search starts one past the last grant and wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr;
        cand        = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_INPUTS);
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign load = (!evt_valid || evt_ready) && grant_found;
    assign take = load ? (NUM_INPUTS'(1) << grant_idx) : '0;

    // A fresh edge always wins the pending slot; it only counts as an
    // overrun when the previous event is not leaving in the same cycle.
    always_comb begin
        pend_d  = pend;
        pol_d   = pol;
        ovr_set = '0;
        for (int c = 0; c < NUM_INPUTS; c++) begin
            if (edge_pulse[c]) begin
                pend_d[c]  = 1'b1;
                pol_d[c]   = edge_rise[c];
                ovr_set[c] = pend[c] && !take[c];
            end else if (take[c]) begin
                pend_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            pol     <= '0;
            overrun <= '0;
        end else begin
            pend    <= pend_d;
            pol     <= pol_d;
            overrun <= (overrun & ~{NUM_INPUTS{overrun_clr}}) | ovr_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            ptr       <= IW'(NUM_INPUTS - 1);
        end else if (load) begin
            evt_valid   <= 1'b1;
            evt_q.index <= MAX_IDX_W'(grant_idx);
            evt_q.rise  <= pol[grant_idx];
            ptr         <= grant_idx;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    assign evt_index  = evt_q.index[IW-1:0];
    assign evt_rise   = evt_q.rise;
    // Upper payload index bits are zero padding for small channel counts.
    assign evt_unused = ^evt_q.index;

endmodule
